// File: rtl/nios2_oci_dct_pkg.sv
// rtl/nios2_oci_dct_pkg.sv - shared types and widths for the DCT capture sink
package nios2_oci_dct_pkg;

  localparam int DCT_DATA_W = 30;
  localparam int DCT_CNT_W  = 4;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// rtl/nios2_oci_dct_fifo.sv - capture FIFO with push/pop arbitration
module nios2_oci_dct_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     head,
  output logic [PTR_W:0]   level,
  output logic [PTR_W:0]   level_next,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             drop
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] wr_ptr_next;
  logic [PTR_W:0] rd_ptr_next;
  logic           full;
  logic           empty;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  // A pop frees the slot a full-FIFO push needs; an empty FIFO never forwards the pushed word.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok);
  assign drop    = push_req && !push_ok;

  assign wr_ptr_next = wr_ptr + (PTR_W+1)'(push_ok);
  assign rd_ptr_next = rd_ptr + (PTR_W+1)'(pop_ok);
  assign level_next  = wr_ptr_next - rd_ptr_next;
  assign head        = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// rtl/nios2_oci_dct_capture.sv - DCT trace capture sink with end-of-test drain; DCT_CAPTURE_DROP_CNT_EN adds drop_count
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int CNT_W  = DCT_CNT_W,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_wr,
  input  logic                    test_ending,
  input  logic                    rd_req,
  output logic [CNT_W+DATA_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic [PTR_W:0]          fifo_level,
  output logic                    overflow,
  output logic                    test_has_ended,
  output logic                    busy
`ifdef DCT_CAPTURE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_count
`endif
);

  localparam int W = CNT_W + DATA_W;

  dct_state_e     state;
  dct_state_e     state_next;
  logic           push_req;
  logic           pop_req;
  logic           push_ok;
  logic           pop_ok;
  logic           drop;
  logic [W-1:0]   head;
  logic [PTR_W:0] level_next;

  nios2_oci_dct_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_req   (push_req),
    .pop_req    (pop_req),
    .wdata      ({dct_count, dct_buffer}),
    .head       (head),
    .level      (fifo_level),
    .level_next (level_next),
    .push_ok    (push_ok),
    .pop_ok     (pop_ok),
    .drop       (drop)
  );

  always_comb begin
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (state)
      ST_RUN: begin
        push_req = dct_wr;
        pop_req  = rd_req;
      end
      ST_DRAIN: pop_req = rd_req;
      default: ;
    endcase
  end

  // Holding off DONE while a pop is issued keeps test_has_ended strictly after the last rd_valid.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (test_ending) state_next = ST_DRAIN;
      ST_DRAIN: if (level_next == '0 && !pop_ok) state_next = ST_DONE;
      default:  state_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= head;
    end
  end

  assign test_has_ended = (state == ST_DONE);
  assign busy           = (state != ST_DONE);

`ifdef DCT_CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

  assign overflow = (drop_count != '0);
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// tb/tb_nios2_oci_dct_capture.sv - scoreboard bench for nios2_oci_dct_capture
module tb_nios2_oci_dct_capture;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int W      = CNT_W + DATA_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic          dct_wr = 1'b0;
  logic          test_ending = 1'b0;
  logic          rd_req = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          test_has_ended;
  logic          busy;
`ifdef DCT_CAPTURE_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  nios2_oci_dct_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_wr         (dct_wr),
    .test_ending    (test_ending),
    .rd_req         (rd_req),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .test_has_ended (test_has_ended),
    .busy           (busy)
`ifdef DCT_CAPTURE_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
  } exp_t;

  // Reference: the captured words as a plain queue, plus the test phase (0 run, 1 drain, 2 done).
  exp_t         exq[$];
  logic [W-1:0] mq[$];
  int           m_phase = 0;
  bit           m_ovf = 0;
  int           m_drops = 0;
  logic [W-1:0] exp_last = '0;
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid) begin
        if (exq.size() == 0) begin
          chk("rd_valid_spurious", rd_valid, 1'b0);
        end else begin
          mon_e = exq.pop_front();
          chk("rd_latency", cyc, mon_e.cyc);
          chk("rd_data", rd_data, mon_e.d);
          exp_last = mon_e.d;
        end
      end else begin
        if (exq.size() > 0 && exq[0].cyc <= cyc) begin
          chk("rd_valid_missing", rd_valid, 1'b1);
          void'(exq.pop_front());
        end
        chk("rd_data_hold", rd_data, exp_last);
      end
    end
  end

  task automatic step(input bit wr, input logic [DATA_W-1:0] b, input logic [CNT_W-1:0] c,
                      input bit te, input bit rr);
    bit   pop;
    bit   push;
    exp_t e;
    dct_wr = wr; dct_buffer = b; dct_count = c; test_ending = te; rd_req = rr;
    pop  = (m_phase != 2) && rr && (mq.size() > 0);
    push = 0;
    if (m_phase == 0 && wr) begin
      if (mq.size() < DEPTH || pop) push = 1;
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (pop) begin
      e.cyc = cyc + 1;
      e.d   = mq.pop_front();
      exq.push_back(e);
    end
    if (push) mq.push_back({c, b});
    if (m_phase == 0 && te) m_phase = 1;
    else if (m_phase == 1 && mq.size() == 0 && !pop) m_phase = 2;
    @(posedge clk);
    #1;
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_phase != 2);
    chk("test_has_ended", test_has_ended, m_phase == 2);
`ifdef DCT_CAPTURE_DROP_CNT_EN
    chk("drop_count", drop_count, m_drops);
`endif
  endtask

  task automatic idle(input int n, input bit te);
    repeat (n) step(0, '0, '0, te, 0);
  endtask

  task automatic do_reset();
    reset_n = 0; dct_wr = 0; rd_req = 0; test_ending = 0;
    #1;
    mq.delete(); exq.delete();
    m_phase = 0; m_ovf = 0; m_drops = 0; exp_last = '0;
    chk("rst_level", fifo_level, 0);
    chk("rst_ended", test_has_ended, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    step(1, 30'h0000_0001, 4'd1, 0, 0);
    step(1, 30'h3FFF_FFFF, 4'd15, 0, 0);
    step(1, 30'h1234_5678, 4'd7, 0, 0);
    repeat (3) step(0, '0, '0, 0, 1);
    idle(2, 0);

    // Fill, push+pop at full, then one dropped push and a full drain.
    do_reset();
    repeat (DEPTH) step(1, 30'($urandom), 4'($urandom), 0, 0);
    step(1, 30'($urandom), 4'($urandom), 0, 1);
    step(1, 30'($urandom), 4'($urandom), 0, 0);
    repeat (DEPTH + 1) step(0, '0, '0, 0, 1);
    idle(2, 0);

    do_reset();
    step(1, 30'h0AAA_0001, 4'd2, 0, 0);
    step(1, 30'h0AAA_0002, 4'd3, 0, 0);
    step(1, 30'h0AAA_0003, 4'd4, 1, 0);
    step(1, 30'h0BBB_0000, 4'd5, 1, 0);
    step(1, 30'h0BBB_0001, 4'd6, 1, 0);
    repeat (3) step(0, '0, '0, 1, 1);
    idle(3, 0);
    step(1, 30'h0CCC_0000, 4'd1, 0, 1);
    idle(1, 0);

    do_reset();
    idle(3, 1);

    // Reset while draining five entries.
    do_reset();
    repeat (5) step(1, 30'($urandom), 4'($urandom), 0, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    do_reset();
    step(1, 30'h0123_4567, 4'd9, 0, 0);
    step(0, '0, '0, 0, 1);
    idle(2, 0);

    repeat (4) step(0, '0, '0, 0, 1);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i < 200) step($urandom_range(0, 9) < 7, 30'($urandom), 4'($urandom), 0, $urandom_range(0, 9) < 3);
      else         step($urandom_range(0, 9) < 4, 30'($urandom), 4'($urandom), 0, $urandom_range(0, 9) < 5);
    end
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 1) == 1, 30'($urandom), 4'($urandom), 1, $urandom_range(0, 2) != 0);
    end
    idle(3, 0);
    chk("pending_reads", exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
